core_mem_port: RTL and testbench

CORE_MEM_PORT -- requirements
Module: core_mem_port

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_port_timer.sv | 27 ++
 rtl/core_mem_port.sv | 140 ++++++++++++++
 tb/tb_core_mem_port.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the core memory port: FSM state encoding and parameter defaults.
package mem_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_timer.sv
// Request timeout counter for core_mem_port; instantiated only when CORE_MEM_PORT_TIMEOUT_EN is defined.
module mem_port_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [7:0] count_q;

  assign expired_o = (count_q == 8'(TIMEOUT - 1));

  // Saturates at TIMEOUT-1 so expired_o stays high until the owner clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/core_mem_port.sv
// Core-side memory port: one active command plus one skid entry, driving a per-core arbiter slot.
// Optional request timeout is enabled with the CORE_MEM_PORT_TIMEOUT_EN macro.
module core_mem_port
  import mem_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wren,
  input  logic [WIDTH-1:0] cmd_address,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_error,
  output logic             request,
  output logic             wren_core,
  output logic [WIDTH-1:0] address_out,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  input  logic             response
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("core_mem_port: TIMEOUT must be in 2..255");
  end

  state_e           state_q;
  logic             act_wren_q;
  logic [WIDTH-1:0] act_addr_q;
  logic [WIDTH-1:0] act_wdata_q;
  logic             skid_valid_q;
  logic             skid_wren_q;
  logic [WIDTH-1:0] skid_addr_q;
  logic [WIDTH-1:0] skid_wdata_q;
  logic             request_q;
  logic             rsp_valid_q;
  logic             rsp_error_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             accept;
  logic             timeout_hit;

  assign cmd_ready   = !skid_valid_q;
  assign accept      = cmd_valid && cmd_ready;

  assign request     = request_q;
  assign wren_core   = act_wren_q;
  assign address_out = act_addr_q;
  assign data_out    = act_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;

`ifdef CORE_MEM_PORT_TIMEOUT_EN
  mem_port_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != ST_REQ),
    .enable_i  (state_q == ST_REQ),
    .expired_o (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every register here is state, so all assignments are non-blocking; the
  // asynchronous reset is what drops request mid-transaction without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      act_wren_q   <= 1'b0;
      act_addr_q   <= '0;
      act_wdata_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_wren_q  <= 1'b0;
      skid_addr_q  <= '0;
      skid_wdata_q <= '0;
      request_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (skid_valid_q) begin
            act_wren_q   <= skid_wren_q;
            act_addr_q   <= skid_addr_q;
            act_wdata_q  <= skid_wdata_q;
            skid_valid_q <= 1'b0;
            request_q    <= 1'b1;
            state_q      <= ST_REQ;
          end else if (accept) begin
            act_wren_q  <= cmd_wren;
            act_addr_q  <= cmd_address;
            act_wdata_q <= cmd_wdata;
            request_q   <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A response arriving on the expiry cycle still completes normally.
          if (response) begin
            rsp_data_q  <= data_in;
            rsp_valid_q <= 1'b1;
            request_q   <= 1'b0;
            state_q     <= ST_GAP;
          end else if (timeout_hit) begin
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            request_q   <= 1'b0;
            state_q     <= ST_GAP;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          request_q <= 1'b0;
        end
      endcase
      // Commands arriving while busy park in the skid entry; placed last so a fill wins over a drain.
      if (accept && state_q != ST_IDLE) begin
        skid_valid_q <= 1'b1;
        skid_wren_q  <= cmd_wren;
        skid_addr_q  <= cmd_address;
        skid_wdata_q <= cmd_wdata;
      end
    end
  end

endmodule

// File: tb/tb_core_mem_port.sv
// Self-checking bench for core_mem_port: directed scenarios plus a randomized run checked
// against a transaction-level model (command queue, arbiter responder, expected completions).
module tb_core_mem_port;

  localparam int W = 32;

  typedef struct {
    logic         wren;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } cmd_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_wren = 1'b0;
  logic [W-1:0] cmd_address = '0;
  logic [W-1:0] cmd_wdata = '0;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_error;
  logic         request;
  logic         wren_core;
  logic [W-1:0] address_out;
  logic [W-1:0] data_out;
  logic [W-1:0] data_in = '0;
  logic         response = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  core_mem_port #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wren    (cmd_wren),
    .cmd_address (cmd_address),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_error   (rsp_error),
    .request     (request),
    .wren_core   (wren_core),
    .address_out (address_out),
    .data_out    (data_out),
    .data_in     (data_in),
    .response    (response)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic wren, input logic [W-1:0] addr, input logic [W-1:0] wdata);
    cmd_valid   = 1'b1;
    cmd_wren    = wren;
    cmd_address = addr;
    cmd_wdata   = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if ({request, wren_core, rsp_valid, rsp_error, cmd_ready} !== 5'b00001) begin n_err++; $display("FAIL reset_ctrl: got %b expected 00001", {request, wren_core, rsp_valid, rsp_error, cmd_ready}); end
    n_cmp++; if (address_out !== '0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", address_out); end
    n_cmp++; if (data_out !== '0) begin n_err++; $display("FAIL reset_wdata: got %h expected 0", data_out); end
    n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rsp_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_load();
    offer(1'b0, 32'h10, $urandom);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL load_ready: got %b expected 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({request, wren_core, address_out} !== {2'b10, 32'h10}) begin n_err++; $display("FAIL load_req[%0d]: got req=%b wren=%b addr=%h expected 1 0 00000010", i, request, wren_core, address_out); end
      if (i == 2) begin response = 1'b1; data_in = 32'hDEADBEEF; end
      tick();
    end
    response = 1'b0;
    data_in = $urandom;
    n_cmp++; if ({rsp_valid, rsp_error, request} !== 3'b100) begin n_err++; $display("FAIL load_rsp_ctrl: got valid=%b err=%b req=%b expected 1 0 0", rsp_valid, rsp_error, request); end
    n_cmp++; if (rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL load_rsp_data: got %h expected deadbeef", rsp_data); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL load_rsp_pulse: got %b expected 0", rsp_valid); end
    tick();
  endtask

  task automatic test_store();
    offer(1'b1, 32'h20, 32'h55);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({request, wren_core, address_out, data_out} !== {2'b11, 32'h20, 32'h55}) begin n_err++; $display("FAIL store_hold[%0d]: got req=%b wren=%b addr=%h data=%h expected 1 1 20 55", i, request, wren_core, address_out, data_out); end
      if (i == 3) begin response = 1'b1; data_in = $urandom; end
      tick();
    end
    response = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_error, request} !== 3'b100) begin n_err++; $display("FAIL store_rsp: got valid=%b err=%b req=%b expected 1 0 0", rsp_valid, rsp_error, request); end
    tick();
    n_cmp++; if (request !== 1'b0) begin n_err++; $display("FAIL store_gap: got %b expected 0", request); end
    tick();
  endtask

  task automatic test_back_to_back();
    offer(1'b0, 32'h100, 32'h0);
    tick();
    offer(1'b1, 32'h200, 32'hB);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_empty: got %b expected 1", cmd_ready); end
    tick();
    offer(1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({cmd_ready, request, address_out} !== {2'b01, 32'h100}) begin n_err++; $display("FAIL b2b_skid_full[%0d]: got ready=%b req=%b addr=%h expected 0 1 100", i, cmd_ready, request, address_out); end
      if (i == 2) begin response = 1'b1; data_in = 32'hA1; end
      tick();
    end
    response = 1'b0;
    n_cmp++; if ({rsp_valid, request, rsp_data} !== {2'b10, 32'hA1}) begin n_err++; $display("FAIL b2b_rsp1: got valid=%b req=%b data=%h expected 1 0 a1", rsp_valid, request, rsp_data); end
    tick();
    n_cmp++; if ({request, cmd_ready} !== 2'b00) begin n_err++; $display("FAIL b2b_idle: got req=%b ready=%b expected 0 0", request, cmd_ready); end
    tick();
    n_cmp++; if ({request, wren_core, address_out, data_out, cmd_ready} !== {2'b11, 32'h200, 32'hB, 1'b1}) begin n_err++; $display("FAIL b2b_launch2: got req=%b wren=%b addr=%h data=%h ready=%b expected 1 1 200 b 1", request, wren_core, address_out, data_out, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_third_parked: got %b expected 0", cmd_ready); end
    response = 1'b1;
    tick();
    response = 1'b0;
    tick();
    tick();
    n_cmp++; if ({request, address_out} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL b2b_launch3: got req=%b addr=%h expected 1 300", request, address_out); end
    response = 1'b1;
    tick();
    response = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ignored_response();
    for (int i = 0; i < 3; i++) begin
      response = (i == 0);
      data_in = $urandom;
      tick();
      n_cmp++; if ({rsp_valid, request} !== 2'b00) begin n_err++; $display("FAIL ignore_rsp[%0d]: got valid=%b req=%b expected 0 0", i, rsp_valid, request); end
    end
  endtask

  task automatic test_timeout();
    int n;
    offer(1'b0, 32'h40, 32'h0);
    tick();
    cmd_valid = 1'b0;
`ifdef CORE_MEM_PORT_TIMEOUT_EN
    n = 0;
    while (request === 1'b1 && n < 40) begin n++; tick(); end
    n_cmp++; if (n !== 16) begin n_err++; $display("FAIL to_cycles: got %0d REQ cycles expected 16", n); end
    n_cmp++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL to_rsp: got valid=%b err=%b data=%h expected 1 1 0", rsp_valid, rsp_error, rsp_data); end
    tick();
    tick();
    offer(1'b0, 32'h44, 32'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    response = 1'b1;
    data_in = 32'h1234;
    tick();
    response = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'h1234}) begin n_err++; $display("FAIL to_coincide: got valid=%b err=%b data=%h expected 1 0 1234", rsp_valid, rsp_error, rsp_data); end
`else
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (request !== 1'b1 || rsp_valid !== 1'b0) n++;
      tick();
    end
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL no_timeout_wait: got %0d bad cycles expected 0", n); end
    response = 1'b1;
    data_in = 32'h77;
    tick();
    response = 1'b0;
    n_cmp++; if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, 32'h77}) begin n_err++; $display("FAIL no_timeout_rsp: got valid=%b err=%b data=%h expected 1 0 77", rsp_valid, rsp_error, rsp_data); end
`endif
    tick();
    tick();
  endtask

  task automatic test_reset_mid_req();
    offer(1'b1, 32'h500, 32'h5);
    tick();
    offer(1'b0, 32'h600, 32'h6);
    tick();
    cmd_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if ({request, wren_core, rsp_valid, rsp_error, cmd_ready} !== 5'b00001) begin n_err++; $display("FAIL rst_mid_ctrl: got %b expected 00001", {request, wren_core, rsp_valid, rsp_error, cmd_ready}); end
    n_cmp++; if ({address_out, data_out, rsp_data} !== '0) begin n_err++; $display("FAIL rst_mid_data: got %h %h %h expected 0", address_out, data_out, rsp_data); end
    tick();
    reset = 1'b0;
    response = 1'b1;
    tick();
    response = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({rsp_valid, request} !== 2'b00) begin n_err++; $display("FAIL rst_mid_after[%0d]: got valid=%b req=%b expected 0 0", i, rsp_valid, request); end
      tick();
    end
  endtask

  task automatic test_random();
    cmd_t pend[$];
    cmd_t cur;
    bit   in_flight = 0, expect_rsp = 0, just_resp = 0, accepted = 0;
    int   delay = 0, done = 0, issued = 0, cyc = 0;
    logic [W-1:0] exp_data = '0;
    cur = '{1'b0, '0, '0};
    cmd_valid = 1'b0;
    response = 1'b0;
    while ((done < 40 || pend.size() != 0 || in_flight || expect_rsp) && cyc < 4000) begin
      n_cmp++;
      if (expect_rsp) begin
        if ({rsp_valid, rsp_error, rsp_data} !== {2'b10, exp_data}) begin n_err++; $display("FAIL rnd_rsp: got valid=%b err=%b data=%h expected 1 0 %h", rsp_valid, rsp_error, rsp_data, exp_data); end
        done++;
      end else if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rnd_spurious_rsp: got %b expected 0", rsp_valid); end
      if (just_resp) begin
        n_cmp++; if (request !== 1'b0) begin n_err++; $display("FAIL rnd_gap: got %b expected 0", request); end
      end else if (request === 1'b1 && !in_flight) begin
        n_cmp++;
        if (pend.size() == 0) begin n_err++; $display("FAIL rnd_launch: got request with no pending command expected none"); end
        else begin
          cur = pend.pop_front();
          if ({wren_core, address_out, data_out} !== {cur.wren, cur.addr, cur.wdata}) begin n_err++; $display("FAIL rnd_launch: got %b %h %h expected %b %h %h", wren_core, address_out, data_out, cur.wren, cur.addr, cur.wdata); end
        end
        in_flight = 1;
        delay = $urandom_range(0, 4);
      end else if (in_flight) begin
        n_cmp++; if ({request, wren_core, address_out, data_out} !== {1'b1, cur.wren, cur.addr, cur.wdata}) begin n_err++; $display("FAIL rnd_hold: got %b %b %h %h expected 1 %b %h %h", request, wren_core, address_out, data_out, cur.wren, cur.addr, cur.wdata); end
      end
      n_cmp++; if (cmd_ready !== (pend.size() == 0)) begin n_err++; $display("FAIL rnd_ready: got %b expected %b", cmd_ready, pend.size() == 0); end
      expect_rsp = 0;
      just_resp = 0;
      response = 1'b0;
      if (in_flight) begin
        if (delay == 0) begin
          response = 1'b1;
          data_in = $urandom;
          exp_data = data_in;
          expect_rsp = 1;
          just_resp = 1;
          in_flight = 0;
        end else delay--;
      end else if (request === 1'b0 && $urandom_range(0, 7) == 0) begin
        response = 1'b1;
        data_in = $urandom;
      end
      if (!cmd_valid || accepted) begin
        if (issued < 40 && $urandom_range(0, 2) != 0) offer(1'($urandom_range(0, 1)), $urandom, $urandom);
        else cmd_valid = 1'b0;
      end
      accepted = cmd_valid && cmd_ready;
      if (accepted) begin pend.push_back('{cmd_wren, cmd_address, cmd_wdata}); issued++; end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    response = 1'b0;
    n_cmp++; if (done !== 40) begin n_err++; $display("FAIL rnd_complete: got %0d completions in %0d cycles expected 40", done, cyc); end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_ignored_response();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
